// File: rtl/prog_loader_seq_pkg.sv
// Shared encodings for the boot-time program loader: segment tags, header
// field positions and the loader FSM states.
package prog_loader_seq_pkg;

    localparam logic        SEG_IMEM = 1'b0;
    localparam logic        SEG_DMEM = 1'b1;
    localparam logic [31:0] SEG_END  = 32'hFFFF_FFFF;

    localparam int HDR_SEG_BIT = 31;
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_BASE,
        ST_DATA,
        ST_FLUSH,
        ST_DONE
    } load_state_e;

endpackage

// File: rtl/prog_loader_seq_line_packer.sv
// Packs a stream of instruction words, lowest slot first, into NWAY-word
// imem lines and emits a one-cycle registered line-write strobe.
module line_packer #(
    parameter int WORD_W = 32,
    parameter int NWAY   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   last_i,
    input  logic                   flush_i,
    input  logic [WORD_W-1:0]      data_i,
    output logic                   close_o,
    output logic                   line_we_o,
    output logic [NWAY*WORD_W-1:0] line_data_o
);

    localparam int SLOT_W = (NWAY > 1) ? $clog2(NWAY) : 1;

    logic [SLOT_W-1:0]            slot_q;
    logic [NWAY-1:0][WORD_W-1:0]  pack_q;
    logic [NWAY-1:0][WORD_W-1:0]  merged_d;
    logic                         line_we_q;
    logic [NWAY*WORD_W-1:0]       line_data_q;

    // NOTE: always_comb assigns every output a default first, so no latch is inferred.
    always_comb begin
        merged_d         = pack_q;
        merged_d[slot_q] = data_i;
    end

    assign close_o = push_i & (last_i | (slot_q == SLOT_W'(NWAY - 1)));

    // NOTE: the pack buffer is reset (not just the slot pointer) because slots a short line never fills must be written as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            pack_q      <= '0;
            line_we_q   <= 1'b0;
            line_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            line_we_q <= 1'b0;
            if (flush_i) begin
                slot_q <= '0;
                pack_q <= '0;
            end else if (push_i) begin
                if (close_o) begin
                    line_we_q   <= 1'b1;
                    line_data_q <= merged_d;
                    pack_q      <= '0;
                    slot_q      <= '0;
                end else begin
                    pack_q <= merged_d;
                    slot_q <= slot_q + 1'b1;
                end
            end
        end
    end

    assign line_we_o   = line_we_q;
    assign line_data_o = line_data_q;

endmodule

// File: rtl/prog_loader_seq.sv
// Boot-time program loader: parses a tagged segment stream into imem/dmem
// writes, holds the core in reset until the end marker, then muxes the core in.
module prog_loader_seq
    import prog_loader_seq_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int NWAY        = 4,
    parameter int ADDR_LEN    = 32,
    parameter int IMEM_ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WORD_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   loading,
    output logic                   core_reset,
    input  logic [ADDR_LEN-1:0]    core_pc,
    input  logic                   core_dmem_we,
    input  logic [ADDR_LEN-1:0]    core_dmem_addr,
    input  logic [WORD_W-1:0]      core_dmem_wdata,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [NWAY*WORD_W-1:0] imem_wdata,
    output logic                   dmem_we,
    output logic [ADDR_LEN-1:0]    dmem_addr,
    output logic [WORD_W-1:0]      dmem_wdata,
    output logic [7:0]             seg_done
);

    localparam int LINE_SHIFT = 2 + $clog2(NWAY);

    load_state_e            state_q, state_d;
    logic [HDR_LEN_W-1:0]   remaining_q;
    logic                   seg_is_dmem_q;
    logic [ADDR_LEN-3:0]    word_addr_q;
    logic [IMEM_ADDR_W-1:0] line_idx_q;
    logic [IMEM_ADDR_W-1:0] imem_addr_q;
    logic                   dmem_we_q;
    logic [ADDR_LEN-1:0]    dmem_addr_q;
    logic [WORD_W-1:0]      dmem_wdata_q;
    logic [7:0]             seg_done_q, seg_done_d;

    logic accept, is_end, last_word, seg_end;
    logic pack_push, pack_flush, line_close, line_we;
    logic [NWAY*WORD_W-1:0] line_data;

    assign in_ready   = (state_q == ST_HDR) | (state_q == ST_BASE) | (state_q == ST_DATA);
    assign accept     = in_valid & in_ready;
    assign is_end     = (in_data == SEG_END[WORD_W-1:0]);
    assign last_word  = (remaining_q == HDR_LEN_W'(1));
    assign pack_push  = accept & (state_q == ST_DATA) & ~seg_is_dmem_q;
    assign pack_flush = accept & (state_q == ST_BASE);

    always_comb begin
        state_d = state_q;
        seg_end = 1'b0;
        unique case (state_q)
            ST_HDR:   if (accept) state_d = is_end ? ST_FLUSH : ST_BASE;
            ST_BASE:  if (accept) begin
                          if (remaining_q == '0) begin
                              state_d = ST_HDR;
                              seg_end = 1'b1;
                          end else begin
                              state_d = ST_DATA;
                          end
                      end
            ST_DATA:  if (accept && last_word) begin
                          state_d = ST_HDR;
                          seg_end = 1'b1;
                      end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_HDR;
        endcase
    end

    assign seg_done_d = (seg_end && seg_done_q != 8'hFF) ? seg_done_q + 8'd1 : seg_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HDR;
            remaining_q   <= '0;
            seg_is_dmem_q <= 1'b0;
            word_addr_q   <= '0;
            line_idx_q    <= '0;
            imem_addr_q   <= '0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            seg_done_q    <= '0;
        end else begin
            state_q    <= state_d;
            seg_done_q <= seg_done_d;
            dmem_we_q  <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    ST_HDR: begin
                        remaining_q   <= in_data[HDR_LEN_LSB +: HDR_LEN_W];
                        seg_is_dmem_q <= (in_data[HDR_SEG_BIT] == SEG_DMEM);
                    end
                    ST_BASE: begin
                        word_addr_q <= in_data[ADDR_LEN-1:2];
                        line_idx_q  <= IMEM_ADDR_W'(in_data >> LINE_SHIFT);
                    end
                    ST_DATA: begin
                        remaining_q <= remaining_q - 1'b1;
                        if (seg_is_dmem_q) begin
                            dmem_we_q    <= 1'b1;
                            dmem_addr_q  <= {2'b00, word_addr_q};
                            dmem_wdata_q <= in_data;
                            word_addr_q  <= word_addr_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Line index travels with the packer's registered strobe.
            if (line_close) begin
                imem_addr_q <= line_idx_q;
                line_idx_q  <= line_idx_q + 1'b1;
            end
        end
    end

    line_packer #(
        .WORD_W (WORD_W),
        .NWAY   (NWAY)
    ) u_line_packer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pack_push),
        .last_i      (last_word),
        .flush_i     (pack_flush),
        .data_i      (in_data),
        .close_o     (line_close),
        .line_we_o   (line_we),
        .line_data_o (line_data)
    );

    assign loading    = (state_q != ST_DONE);
    assign core_reset = reset | loading;
    assign seg_done   = seg_done_q;

    // Once loaded, imem is read-only from the core's fetch PC; dmem is the core's.
    assign imem_we    = loading & line_we;
    assign imem_addr  = loading ? imem_addr_q : core_pc[IMEM_ADDR_W+3:4];
    assign imem_wdata = line_data;
    assign dmem_we    = loading ? dmem_we_q    : core_dmem_we;
    assign dmem_addr  = loading ? dmem_addr_q  : core_dmem_addr;
    assign dmem_wdata = loading ? dmem_wdata_q : core_dmem_wdata;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{core_pc[ADDR_LEN-1:IMEM_ADDR_W+4], core_pc[3:0]};

endmodule

// File: tb/tb_prog_loader_seq.sv
// Self-checking bench for prog_loader_seq: directed and randomized segments
// compared against a segment-level reference model of the expected writes.
module tb_prog_loader_seq;

    localparam int WORD_W      = 32;
    localparam int NWAY        = 4;
    localparam int ADDR_LEN    = 32;
    localparam int IMEM_ADDR_W = 9;
    localparam int LINE_W      = NWAY * WORD_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [WORD_W-1:0]      in_data;
    logic                   in_ready;
    logic                   loading;
    logic                   core_reset;
    logic [ADDR_LEN-1:0]    core_pc;
    logic                   core_dmem_we;
    logic [ADDR_LEN-1:0]    core_dmem_addr;
    logic [WORD_W-1:0]      core_dmem_wdata;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [LINE_W-1:0]      imem_wdata;
    logic                   dmem_we;
    logic [ADDR_LEN-1:0]    dmem_addr;
    logic [WORD_W-1:0]      dmem_wdata;
    logic [7:0]             seg_done;

    always #5 clk = ~clk;

    prog_loader_seq #(
        .WORD_W(WORD_W), .NWAY(NWAY), .ADDR_LEN(ADDR_LEN), .IMEM_ADDR_W(IMEM_ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .loading(loading), .core_reset(core_reset),
        .core_pc(core_pc), .core_dmem_we(core_dmem_we), .core_dmem_addr(core_dmem_addr),
        .core_dmem_wdata(core_dmem_wdata), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .seg_done(seg_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int gap_max  = 0;
    int exp_seg_done = 0;

    logic [IMEM_ADDR_W-1:0] obs_ia[$], exp_ia[$];
    logic [LINE_W-1:0]      obs_id[$], exp_id[$];
    logic [ADDR_LEN-1:0]    obs_da[$], exp_da[$];
    logic [WORD_W-1:0]      obs_dd[$], exp_dd[$];

    // Write monitor: records loader-phase writes on the falling edge.
    always @(negedge clk) begin
        if (!reset && loading) begin
            if (imem_we) begin
                obs_ia.push_back(imem_addr);
                obs_id.push_back(imem_wdata);
            end
            if (dmem_we) begin
                obs_da.push_back(dmem_addr);
                obs_dd.push_back(dmem_wdata);
            end
        end
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_queues();
        obs_ia.delete(); obs_id.delete(); obs_da.delete(); obs_dd.delete();
        exp_ia.delete(); exp_id.delete(); exp_da.delete(); exp_dd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_seg_done = 0;
        clear_queues();
    endtask

    task automatic send(input logic [WORD_W-1:0] w);
        int guard;
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 20) check("accept timeout", LINE_W'(in_ready), LINE_W'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference model: expected writes of one segment derived from the stream rules.
    task automatic model_segment(input bit is_dmem, input logic [31:0] base, input logic [31:0] words[$]);
        int nlines;
        logic [LINE_W-1:0] line;
        if (is_dmem) begin
            for (int i = 0; i < words.size(); i++) begin
                exp_da.push_back((base + 32'(4 * i)) >> 2);
                exp_dd.push_back(words[i]);
            end
        end else begin
            nlines = (words.size() + NWAY - 1) / NWAY;
            for (int l = 0; l < nlines; l++) begin
                line = '0;
                for (int s = 0; s < NWAY; s++)
                    if (l * NWAY + s < words.size())
                        line[s*WORD_W +: WORD_W] = words[l*NWAY + s];
                exp_ia.push_back(IMEM_ADDR_W'(base / (4 * NWAY) + 32'(l)));
                exp_id.push_back(line);
            end
        end
        if (exp_seg_done < 255) exp_seg_done++;
    endtask

    task automatic send_segment(input bit is_dmem, input logic [31:0] base, input logic [31:0] words[$]);
        send({is_dmem, 15'd0, 16'(words.size())});
        send(base);
        foreach (words[i]) send(words[i]);
        model_segment(is_dmem, base, words);
    endtask

    task automatic compare_writes(input string tag);
        repeat (3) @(negedge clk);
        check({tag, " imem count"}, LINE_W'(obs_ia.size()), LINE_W'(exp_ia.size()));
        for (int i = 0; i < exp_ia.size() && i < obs_ia.size(); i++) begin
            check($sformatf("%s imem addr %0d", tag, i), LINE_W'(obs_ia[i]), LINE_W'(exp_ia[i]));
            check($sformatf("%s imem data %0d", tag, i), obs_id[i], exp_id[i]);
        end
        check({tag, " dmem count"}, LINE_W'(obs_da.size()), LINE_W'(exp_da.size()));
        for (int i = 0; i < exp_da.size() && i < obs_da.size(); i++) begin
            check($sformatf("%s dmem addr %0d", tag, i), LINE_W'(obs_da[i]), LINE_W'(exp_da[i]));
            check($sformatf("%s dmem data %0d", tag, i), LINE_W'(obs_dd[i]), LINE_W'(exp_dd[i]));
        end
        check({tag, " seg_done"}, LINE_W'(seg_done), LINE_W'(exp_seg_done));
        clear_queues();
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] rbase;
        int          rlen;
        bit          rdmem;

        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        core_pc = '0; core_dmem_we = 1'b0; core_dmem_addr = '0; core_dmem_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset core_reset", LINE_W'(core_reset), LINE_W'(1));
        reset = 1'b0;
        @(negedge clk);
        check("reset loading",    LINE_W'(loading),    LINE_W'(1));
        check("reset core_reset after release", LINE_W'(core_reset), LINE_W'(1));
        check("reset imem_we",    LINE_W'(imem_we),    LINE_W'(0));
        check("reset dmem_we",    LINE_W'(dmem_we),    LINE_W'(0));
        check("reset seg_done",   LINE_W'(seg_done),   LINE_W'(0));
        check("reset in_ready",   LINE_W'(in_ready),   LINE_W'(1));

        // Directed dmem segment.
        words = '{32'hA, 32'hB, 32'hC};
        send_segment(1'b1, 32'h100, words);
        compare_writes("dmem3");

        // Directed imem segment: lines 2 and 3.
        words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        send_segment(1'b0, 32'h20, words);
        compare_writes("imem6");

        // Same imem segment and random segments with random in_valid gaps.
        gap_max = 3;
        words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        send_segment(1'b0, 32'h20, words);
        compare_writes("imem6 gaps");
        for (int k = 0; k < 4; k++) begin
            rdmem = 1'($urandom_range(1, 0));
            rbase = $urandom;
            rlen  = $urandom_range(9, 1);
            words.delete();
            for (int i = 0; i < rlen; i++) words.push_back($urandom);
            send_segment(rdmem, rbase, words);
            compare_writes($sformatf("rand seg %0d", k));
        end
        gap_max = 0;

        // Zero-length segment, then the end marker.
        words.delete();
        send_segment(1'b0, 32'h40, words);
        compare_writes("zero len");
        in_valid = 1'b1;
        in_data  = '1;
        check("end in_ready before", LINE_W'(in_ready), LINE_W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("flush in_ready",  LINE_W'(in_ready), LINE_W'(0));
        check("flush loading",   LINE_W'(loading),  LINE_W'(1));
        @(negedge clk);
        check("done loading",    LINE_W'(loading),    LINE_W'(0));
        check("done core_reset", LINE_W'(core_reset), LINE_W'(0));
        check("done in_ready",   LINE_W'(in_ready),   LINE_W'(0));
        check("done imem writes", LINE_W'(obs_ia.size()), LINE_W'(0));
        check("done dmem writes", LINE_W'(obs_da.size()), LINE_W'(0));

        // Core owns the memory ports; stream words are ignored.
        in_valid = 1'b1;
        in_data  = 32'h8000_0002;
        for (int k = 0; k < 4; k++) begin
            core_pc         = $urandom;
            core_dmem_we    = 1'($urandom_range(1, 0));
            core_dmem_addr  = $urandom;
            core_dmem_wdata = $urandom;
            #1;
            check($sformatf("pass dmem_we %0d", k),    LINE_W'(dmem_we),    LINE_W'(core_dmem_we));
            check($sformatf("pass dmem_addr %0d", k),  LINE_W'(dmem_addr),  LINE_W'(core_dmem_addr));
            check($sformatf("pass dmem_wdata %0d", k), LINE_W'(dmem_wdata), LINE_W'(core_dmem_wdata));
            check($sformatf("pass imem_addr %0d", k),  LINE_W'(imem_addr),  LINE_W'((core_pc >> 4) & 32'h1FF));
            check($sformatf("pass imem_we %0d", k),    LINE_W'(imem_we),    LINE_W'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("done stays",  LINE_W'(loading),  LINE_W'(0));
        check("done seg_done", LINE_W'(seg_done), LINE_W'(exp_seg_done));

        // Reset in the middle of an imem segment, then reload it fully.
        do_reset();
        send({1'b0, 15'd0, 16'd4});
        send(32'h50);
        send(32'h11);
        send(32'h22);
        do_reset();
        repeat (2) @(negedge clk);
        check("abort imem writes", LINE_W'(obs_ia.size()), LINE_W'(0));
        check("abort seg_done",    LINE_W'(seg_done),      LINE_W'(0));
        check("abort loading",     LINE_W'(loading),       LINE_W'(1));
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_segment(1'b0, 32'h50, words);
        compare_writes("reload");

        // seg_done saturation.
        do_reset();
        words.delete();
        for (int k = 0; k < 260; k++) send_segment(1'b1, 32'h0, words);
        compare_writes("saturate");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
